// File: rtl/sqrt_seq_unit_pkg.sv
// Shared definitions for the sequential square-root engine: FSM state
// encoding and the width helper for the iteration counter.
package sqrt_seq_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/sqrt_seq_unit_iter_step.sv
// One radix-4 digit of the restoring square root: brings in two radicand
// bits and retires one root bit.
module sqrt_iter_step #(
  parameter int HALF = 8
) (
  input  logic [HALF+1:0] rem,
  input  logic [HALF-1:0] root,
  input  logic [1:0]      bits,
  output logic [HALF+1:0] nxt_rem,
  output logic [HALF-1:0] nxt_root
);

  logic [HALF+1:0] shifted;
  logic [HALF+1:0] trial;

  always_comb begin
    shifted  = (rem << 2) | (HALF+2)'(bits);
    trial    = {root, 2'b01};
    nxt_rem  = shifted;
    nxt_root = root << 1;
    if (shifted >= trial) begin
      nxt_rem  = shifted - trial;
      nxt_root = (root << 1) | HALF'(1);
    end
  end

endmodule

// File: rtl/sqrt_seq_unit.sv
// Sequential integer square root, two radicand bits per clock, with a
// start/busy/done handshake and optional round-to-nearest with saturation.
module sqrt_seq_unit
  import sqrt_seq_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic               i_clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic [WIDTH-1:0]   i_Radicand,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [WIDTH/2-1:0] o_Root,
  output logic [WIDTH/2:0]   o_Remainder,
  output logic               o_Sat
);

  localparam int HALF  = WIDTH / 2;
  localparam int ITER  = HALF;
  localparam int CNT_W = (clog2(ITER) < 1) ? 1 : clog2(ITER);

  state_e           state;
  logic [WIDTH-1:0] rad_sr;
  logic [HALF+1:0]  work_rem;
  logic [HALF-1:0]  work_root;
  logic [CNT_W-1:0] count;

  logic [HALF+1:0]  nxt_rem;
  logic [HALF-1:0]  nxt_root;
  logic [HALF:0]    rnd;

  // Returns {sat, root}; the remainder always stays relative to the floor root.
  function automatic logic [HALF:0] round_root(input logic [HALF-1:0] froot,
                                               input logic [HALF+1:0] rem);
    logic [HALF-1:0] r;
    logic            sat;
    r   = froot;
    sat = 1'b0;
    if ((ROUND != 0) && (rem > {2'b00, froot})) begin
      if (froot == {HALF{1'b1}}) sat = 1'b1;
      else                       r   = froot + 1'b1;
    end
    return {sat, r};
  endfunction

  sqrt_iter_step #(.HALF(HALF)) u_step (
    .rem      (work_rem),
    .root     (work_root),
    .bits     (rad_sr[WIDTH-1 -: 2]),
    .nxt_rem  (nxt_rem),
    .nxt_root (nxt_root)
  );

  always_comb rnd = round_root(nxt_root, nxt_rem);

  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      rad_sr      <= '0;
      work_rem    <= '0;
      work_root   <= '0;
      count       <= '0;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Root      <= '0;
      o_Remainder <= '0;
      o_Sat       <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            rad_sr    <= i_Radicand;
            work_rem  <= '0;
            work_root <= '0;
            count     <= CNT_W'(ITER - 1);
            o_Busy    <= 1'b1;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          rad_sr    <= rad_sr << 2;
          work_rem  <= nxt_rem;
          work_root <= nxt_root;
          if (count == '0) begin
            // Final digit: publish straight from the step outputs.
            state       <= ST_IDLE;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b1;
            o_Root      <= rnd[HALF-1:0];
            o_Sat       <= rnd[HALF];
            o_Remainder <= nxt_rem[HALF:0];
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
